io_uart_tx: RTL

- Wishbone B4 classic slave on the core's io port, the responder end of the io bus initiator.
- Accepts bytes from software into a FIFO and serialises them on an 8N1 UART line.
- Produces a level interrupt when the FIFO drains; the line is wired to one bit of the core's interrupts vector.
- Occupies the 6-bit io address space: four 32-bit word registers, decoded on wbs_addr[3:2].

---
 rtl/io_uart_tx_if.sv | 23 ++
 rtl/io_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: Wishbone B4 classic io-port signals between the core's io bus
// initiator (master) and the io_uart_tx responder (slave).
interface io_uart_tx_if;
    logic [5:0]  wbs_addr;
    logic [31:0] wbs_dat_w;
    logic [3:0]  wbs_sel;
    logic        wbs_we;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic [31:0] wbs_dat_r;
    logic        wbs_ack;
    logic        wbs_err;

    modport master (
        output wbs_addr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
        input  wbs_dat_r, wbs_ack, wbs_err
    );

    modport slave (
        input  wbs_addr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
        output wbs_dat_r, wbs_ack, wbs_err
    );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: Wishbone B4 classic slave feeding an 8N1 UART transmitter through a TX FIFO.
// Defining UART_TX_PARITY_EN adds an optional even/odd parity bit controlled from CTRL[2:1].
module io_uart_tx #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    io_uart_tx_if.slave wb,
    output logic        uart_tx,
    output logic        irq
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wptr_r, rptr_r, level_s;
    logic        full_s, empty_s, busy_s;
    logic [7:0]  head_s;

    tx_state_t   state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        tx_r, line_s, pop_s, irq_r;

    logic [15:0] div_r;
    logic        irq_en_r, par_odd_s;
    logic        req_s, push_s, ack_s, err_s, wr_div_s, wr_ctrl_s;
    logic        ack_r, err_r;
    logic [31:0] rd_mux_s, rdata_s, rdata_r, status_s, ctrl_s;
    logic        unused_s;

`ifdef UART_TX_PARITY_EN
    logic par_en_r, par_odd_r;
    assign par_odd_s = par_odd_r;
    assign ctrl_s    = {29'd0, par_odd_r, par_en_r, irq_en_r};
`else
    assign par_odd_s = 1'b0;
    assign ctrl_s    = {31'd0, irq_en_r};
`endif

    assign level_s  = wptr_r - rptr_r;
    assign empty_s  = (wptr_r == rptr_r);
    assign full_s   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign head_s   = mem_r[rptr_r[AW-1:0]];
    assign busy_s   = (state_r != ST_IDLE);
    assign status_s = {16'd0, 8'(level_s), 5'd0, empty_s, full_s, busy_s};
    assign unused_s = ^{wb.wbs_dat_w[31:16], wb.wbs_sel[3:2], wb.wbs_addr[5:4], wb.wbs_addr[1:0]};

    assign wb.wbs_ack   = ack_r;
    assign wb.wbs_err   = err_r;
    assign wb.wbs_dat_r = rdata_r;
    assign uart_tx      = tx_r;
    assign irq          = irq_r;

    // Decode one bus request into FIFO push, register writes and the next response.
    always_comb begin
        req_s     = wb.wbs_cyc & wb.wbs_stb & ~ack_r & ~err_r;
        push_s    = 1'b0;
        ack_s     = 1'b0;
        err_s     = 1'b0;
        wr_div_s  = 1'b0;
        wr_ctrl_s = 1'b0;
        case (wb.wbs_addr[3:2])
            2'd1:    rd_mux_s = status_s;
            2'd2:    rd_mux_s = {16'd0, div_r};
            2'd3:    rd_mux_s = ctrl_s;
            default: rd_mux_s = 32'd0;
        endcase
        if (req_s && wb.wbs_we) begin
            // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
            if ((wb.wbs_addr[3:2] == 2'd0) && wb.wbs_sel[0] && full_s && !pop_s) begin
                err_s = 1'b1;
            end else begin
                ack_s     = 1'b1;
                push_s    = (wb.wbs_addr[3:2] == 2'd0) && wb.wbs_sel[0];
                wr_div_s  = (wb.wbs_addr[3:2] == 2'd2);
                wr_ctrl_s = (wb.wbs_addr[3:2] == 2'd3);
            end
        end else if (req_s) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
        rdata_s = (req_s && !wb.wbs_we) ? rd_mux_s : 32'd0;
    end

    // Bus response and software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'd0;
            div_r    <= DIV_RESET;
            irq_en_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
`endif
        end else begin
            ack_r   <= ack_s;
            err_r   <= err_s;
            rdata_r <= rdata_s;
            if (wr_div_s && wb.wbs_sel[0]) div_r[7:0]  <= wb.wbs_dat_w[7:0];
            if (wr_div_s && wb.wbs_sel[1]) div_r[15:8] <= wb.wbs_dat_w[15:8];
            if (wr_ctrl_s && wb.wbs_sel[0]) begin
                irq_en_r <= wb.wbs_dat_w[0];
`ifdef UART_TX_PARITY_EN
                par_en_r  <= wb.wbs_dat_w[1];
                par_odd_r <= wb.wbs_dat_w[2];
`endif
            end
        end
    end

    // FIFO pointers; the extra wrap bit separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_s) wptr_r <= wptr_r + PTR_ONE;
            if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wptr_r[AW-1:0]] <= wb.wbs_dat_w[7:0];
    end

    // TX next-state logic: every bit lasts DIVISOR+1 cycles, timer reloaded at each boundary.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    cnt_s   = div_r;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_DATA;
                    idx_s   = 3'd0;
                    cnt_s   = div_r;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == 16'd0) begin
                    cnt_s = div_r;
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = par_en_r ? ST_PARITY : ST_STOP;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_STOP;
                    cnt_s   = div_r;
                end else begin
                    cnt_s = cnt_r - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    cnt_s   = div_r;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        case (state_s)
            ST_START: line_s = 1'b0;
            ST_DATA:  line_s = shift_s[idx_s];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_s = even_parity(shift_s) ^ par_odd_s;
`endif
            default:  line_s = 1'b1;
        endcase
    end

    // TX state, bit timer, shifter and the registered line and interrupt outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            tx_r    <= line_s;
            irq_r   <= irq_en_r & empty_s & (state_r == ST_IDLE);
        end
    end
endmodule
